// File: rtl/upc_scan_latch.sv
`default_nettype none
// ============================================================================
// Module   : upc_scan_latch
// Purpose  : Upstream stage of the UPC display path. Synchronizes the 3-bit
//            UPC switch code and the scan/clear buttons, debounces the scan
//            button and, on each clean press, captures the switch code into
//            a held register that feeds the display stage. Also keeps a
//            saturating capture counter.
// Options  : UPC_SCAN_HISTORY_EN - when defined, adds prev_upc / prev_valid
//            holding the code that was displaced by the latest capture.
// Revision : 1.0 - initial release
// ============================================================================
module upc_scan_latch #(
    parameter int DEBOUNCE_CYCLES = 4,   // consecutive samples to accept a press/release (2..2^20)
    parameter int CNT_W           = 8    // width of scan_count
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       sw_upc,
    input  logic             key_scan_n,
    input  logic             key_clear_n,
    output logic [2:0]       upc,
    output logic             upc_valid,
    output logic             scan_pulse,
    output logic [CNT_W-1:0] scan_count
`ifdef UPC_SCAN_HISTORY_EN
    ,
    output logic [2:0]       prev_upc,
    output logic             prev_valid
`endif
);

    // Debounce counter only ever reaches DEBOUNCE_CYCLES-1, so clog2 bits suffice.
    localparam int                c_DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_DB_W-1:0] c_DB_ONE  = c_DB_W'(1);
    localparam logic [c_DB_W-1:0] c_DB_ZERO = '0;
    localparam logic [CNT_W-1:0]  c_CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRESS_DB = 2'd1,
        ST_WAIT_REL = 2'd2,
        ST_REL_DB   = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Synchronizers
    // ------------------------------------------------------------------------
    logic [1:0] r_key_sync;
    logic [1:0] r_clr_sync;
    logic [2:0] r_sw_meta;
    logic [2:0] r_sw_sync;

    logic       w_key_s;
    logic       w_clr_s;
    logic [2:0] w_sw_s;

    // Two-flop synchronizers; buttons preset to the released level so a reset
    // never looks like a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_key_sync <= 2'b11;
            r_clr_sync <= 2'b11;
            r_sw_meta  <= 3'b000;
            r_sw_sync  <= 3'b000;
        end else begin
            r_key_sync <= {r_key_sync[0], key_scan_n};
            r_clr_sync <= {r_clr_sync[0], key_clear_n};
            r_sw_meta  <= sw_upc;
            r_sw_sync  <= r_sw_meta;
        end
    end

    assign w_key_s = r_key_sync[1];
    assign w_clr_s = r_clr_sync[1];
    assign w_sw_s  = r_sw_sync;

    // ------------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_DB_W-1:0]  r_db_cnt;
    logic [c_DB_W-1:0]  w_db_cnt_nxt;
    logic               w_press_done;

    // State and debounce counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_db_cnt <= c_DB_ZERO;
        end else begin
            r_state  <= w_state_nxt;
            r_db_cnt <= w_db_cnt_nxt;
        end
    end

    // Next-state logic: a press must stay low for DEBOUNCE_CYCLES samples to
    // capture, and the release must stay high as long before re-arming.
    always_comb begin
        w_state_nxt  = r_state;
        w_db_cnt_nxt = r_db_cnt;
        w_press_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_key_s) begin
                    w_state_nxt  = ST_PRESS_DB;
                    w_db_cnt_nxt = c_DB_ONE;
                end
            end
            ST_PRESS_DB: begin
                if (w_key_s) begin
                    w_state_nxt  = ST_IDLE;
                    w_db_cnt_nxt = c_DB_ZERO;
                end else if (r_db_cnt == c_DB_LAST) begin
                    w_state_nxt  = ST_WAIT_REL;
                    w_db_cnt_nxt = c_DB_ZERO;
                    w_press_done = 1'b1;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + c_DB_ONE;
                end
            end
            ST_WAIT_REL: begin
                if (w_key_s) begin
                    w_state_nxt  = ST_REL_DB;
                    w_db_cnt_nxt = c_DB_ONE;
                end
            end
            ST_REL_DB: begin
                if (!w_key_s) begin
                    w_state_nxt  = ST_WAIT_REL;
                    w_db_cnt_nxt = c_DB_ZERO;
                end else if (r_db_cnt == c_DB_LAST) begin
                    w_state_nxt  = ST_IDLE;
                    w_db_cnt_nxt = c_DB_ZERO;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + c_DB_ONE;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_db_cnt_nxt = c_DB_ZERO;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Capture registers
    // ------------------------------------------------------------------------
    logic [2:0]       r_upc;
    logic             r_upc_valid;
    logic             r_scan_pulse;
    logic [CNT_W-1:0] r_scan_count;
    logic             w_cnt_full;

    // Clear suppresses a coincident capture; the FSM still advances regardless.
    assign w_cnt_full = &r_scan_count;

    // Held code, valid flag, strobe and saturating capture count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_upc        <= 3'b000;
            r_upc_valid  <= 1'b0;
            r_scan_pulse <= 1'b0;
            r_scan_count <= '0;
        end else if (!w_clr_s) begin
            r_upc        <= 3'b000;
            r_upc_valid  <= 1'b0;
            r_scan_pulse <= 1'b0;
            r_scan_count <= '0;
        end else if (w_press_done) begin
            r_upc        <= w_sw_s;
            r_upc_valid  <= 1'b1;
            r_scan_pulse <= 1'b1;
            r_scan_count <= w_cnt_full ? r_scan_count : (r_scan_count + c_CNT_ONE);
        end else begin
            r_scan_pulse <= 1'b0;
        end
    end

    assign upc        = r_upc;
    assign upc_valid  = r_upc_valid;
    assign scan_pulse = r_scan_pulse;
    assign scan_count = r_scan_count;

`ifdef UPC_SCAN_HISTORY_EN
    logic [2:0] r_prev_upc;
    logic       r_prev_valid;

    // Remember the code displaced by each capture; clear wipes the history too.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev_upc   <= 3'b000;
            r_prev_valid <= 1'b0;
        end else if (!w_clr_s) begin
            r_prev_upc   <= 3'b000;
            r_prev_valid <= 1'b0;
        end else if (w_press_done) begin
            r_prev_upc   <= r_upc;
            r_prev_valid <= r_upc_valid;
        end
    end

    assign prev_upc   = r_prev_upc;
    assign prev_valid = r_prev_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_upc_scan_latch.sv
`default_nettype none
// ============================================================================
// Module   : tb_upc_scan_latch
// Purpose  : Scoreboard bench for upc_scan_latch (DEBOUNCE_CYCLES=4, CNT_W=8).
//            Stimulus pushes the expected capture (code, count, cycle) when a
//            press starts; a monitor pops and compares on every scan_pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_upc_scan_latch;

    logic       clk;
    logic       reset_n;
    logic [2:0] sw_upc;
    logic       key_scan_n;
    logic       key_clear_n;
    logic [2:0] upc;
    logic       upc_valid;
    logic       scan_pulse;
    logic [7:0] scan_count;
`ifdef UPC_SCAN_HISTORY_EN
    logic [2:0] prev_upc;
    logic       prev_valid;
`endif

    upc_scan_latch #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sw_upc      (sw_upc),
        .key_scan_n  (key_scan_n),
        .key_clear_n (key_clear_n),
        .upc         (upc),
        .upc_valid   (upc_valid),
        .scan_pulse  (scan_pulse),
        .scan_count  (scan_count)
`ifdef UPC_SCAN_HISTORY_EN
        ,
        .prev_upc    (prev_upc),
        .prev_valid  (prev_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] code;
        int         cnt;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected capture for a press whose first low sample is the next edge:
    // capture lands on the 6th rising edge from now.
    task automatic push_capture(input logic [2:0] code);
        exp_t e;
        m_cnt  = (m_cnt == 255) ? 255 : m_cnt + 1;
        e.code = code;
        e.cnt  = m_cnt;
        e.cyc  = cyc + 6;
        q.push_back(e);
    endtask

    task automatic press(input logic [2:0] code, input int hold, input int rel);
        sw_upc     = code;
        key_scan_n = 1'b0;
        push_capture(code);
        wait_n(hold);
        key_scan_n = 1'b1;
        wait_n(rel);
    endtask

    // Monitor: every strobe must match the oldest expectation, on time.
    always @(negedge clk) begin
        if (reset_n) begin
            if (scan_pulse) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pulse: got pulse expected none (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("cap_upc",   int'(upc),        int'(e.code));
                    chk("cap_count", int'(scan_count), e.cnt);
                    chk("cap_valid", int'(upc_valid),  1);
                    chk("cap_cycle", cyc,              e.cyc);
                end
            end else if (q.size() > 0 && cyc > q[0].cyc) begin
                n_cmp++;
                n_err++;
                $display("FAIL capture_timeout: got no pulse by cycle %0d expected at %0d", cyc, q[0].cyc);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n     = 1'b0;
        key_scan_n  = 1'b1;
        key_clear_n = 1'b1;
        sw_upc      = 3'b000;
        wait_n(3);
        chk("rst_upc",   int'(upc),        0);
        chk("rst_valid", int'(upc_valid),  0);
        chk("rst_pulse", int'(scan_pulse), 0);
        chk("rst_count", int'(scan_count), 0);
        reset_n = 1'b1;
        m_cnt   = 0;
        wait_n(2);

        // Long hold: one capture of 5 at edge 5, nothing more while held.
        press(3'b101, 20, 6);
        chk("t1_upc",   int'(upc),        5);
        chk("t1_valid", int'(upc_valid),  1);
        chk("t1_count", int'(scan_count), 1);

        // Bouncy press never reaches four consecutive low samples.
        key_scan_n = 1'b0; wait_n(2);
        key_scan_n = 1'b1; wait_n(1);
        key_scan_n = 1'b0; wait_n(2);
        key_scan_n = 1'b1; wait_n(8);
        // Switch activity between captures must not reach upc.
        sw_upc = 3'b011; wait_n(3);
        sw_upc = 3'b110; wait_n(3);
        chk("bounce_upc",   int'(upc),        5);
        chk("bounce_count", int'(scan_count), 1);

        press(3'b010, 10, 6);
        chk("t3_upc",   int'(upc),        2);
        chk("t3_count", int'(scan_count), 2);
`ifdef UPC_SCAN_HISTORY_EN
        chk("hist_prev_upc",   int'(prev_upc),   5);
        chk("hist_prev_valid", int'(prev_valid), 1);
`endif

        // Code sampled at edge 3 is captured; a change seen from edge 4 is not.
        sw_upc = 3'b110; key_scan_n = 1'b0; push_capture(3'b110);
        wait_n(4); sw_upc = 3'b001;
        wait_n(6); key_scan_n = 1'b1; wait_n(6);
        chk("samp_late_upc", int'(upc), 6);
        // A change already seen at edge 3 is captured.
        sw_upc = 3'b110; key_scan_n = 1'b0; push_capture(3'b001);
        wait_n(3); sw_upc = 3'b001;
        wait_n(7); key_scan_n = 1'b1; wait_n(6);
        chk("samp_edge_upc", int'(upc), 1);

        press(3'b011, 6, 6);
        press(3'b100, 6, 6);
        press(3'b111, 6, 6);
        chk("pre_clr_count", int'(scan_count), 7);

        // Clear: registered two edges after the first low sample.
        key_clear_n = 1'b0;
        wait_n(3);
        chk("clr_upc",   int'(upc),        0);
        chk("clr_valid", int'(upc_valid),  0);
        chk("clr_count", int'(scan_count), 0);
`ifdef UPC_SCAN_HISTORY_EN
        chk("clr_prev_upc",   int'(prev_upc),   0);
        chk("clr_prev_valid", int'(prev_valid), 0);
`endif
        m_cnt = 0;
        wait_n(2);
        key_clear_n = 1'b1;
        wait_n(4);

        press(3'b011, 6, 6);
        chk("pre_win_count", int'(scan_count), 1);

        // Clear seen only on the capture edge: no capture, state still clears.
        sw_upc = 3'b100; key_scan_n = 1'b0;
        wait_n(3); key_clear_n = 1'b0;
        wait_n(1); key_clear_n = 1'b1;
        wait_n(6);
        chk("win_upc",   int'(upc),        0);
        chk("win_valid", int'(upc_valid),  0);
        chk("win_count", int'(scan_count), 0);
        m_cnt = 0;
        // Still held: FSM must be waiting for release, so no capture here.
        wait_n(10);
        key_scan_n = 1'b1;
        wait_n(6);
        press(3'b101, 6, 6);
        chk("after_win_upc", int'(upc), 5);

        // Saturation: count stops at 255 but every press still strobes.
        for (int i = 0; i < 300; i++) begin
            press(3'(i % 8), 6, 6);
        end
        chk("sat_count", int'(scan_count), 255);
        chk("sat_upc",   int'(upc),        3);

        // Async reset in the middle of a press debounce.
        sw_upc = 3'b010; key_scan_n = 1'b0;
        wait_n(4);
        reset_n = 1'b0;
        #1;
        chk("midrst_upc",   int'(upc),        0);
        chk("midrst_valid", int'(upc_valid),  0);
        chk("midrst_pulse", int'(scan_pulse), 0);
        chk("midrst_count", int'(scan_count), 0);
        wait_n(2);
        reset_n = 1'b1;
        m_cnt   = 0;
        push_capture(3'b010);
        wait_n(10);
        key_scan_n = 1'b1;
        wait_n(6);
        chk("midrst_cap_count", int'(scan_count), 1);

        wait_n(20);
        while (q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL missing_capture: got no pulse expected code %0d count %0d", q[0].code, q[0].cnt);
            void'(q.pop_front());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
